// File: rtl/memory_arbiter.sv
// Unified RAM arbiter between instruction fetch and data memory.
// Data has priority; a starvation counter forces a fetch grant.
module memory_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic        ram_ready
);

   typedef enum logic [1:0] {
      IDLE,
      DSERVE,
      ISERVE
   } state_e;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_e     state_q, state_d;
   logic [3:0] scnt_q, scnt_d;
   logic       dreq;
   logic       starved;

   assign dreq    = dREN | dWEN;
   assign starved = iREN & (scnt_q == LIMIT);

   // State and starvation counter registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         scnt_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
      end
   end

   // Next-state: grant selection in IDLE, exit on completion or abort
   always_comb begin
      state_d = state_q;
      scnt_d  = scnt_q;
      case (state_q)
         IDLE: begin
            if (dreq && !starved) begin
               state_d = DSERVE;
               if (!iREN)
                  scnt_d = 4'd0;
               else if (scnt_q >= LIMIT)
                  scnt_d = LIMIT;
               else
                  scnt_d = scnt_q + 4'd1;
            end else if (iREN) begin
               state_d = ISERVE;
               scnt_d  = 4'd0;
            end else begin
               scnt_d  = 4'd0;
            end
         end
         DSERVE: begin
            if (ram_ready || !dreq)
               state_d = IDLE;
         end
         ISERVE: begin
            if (ram_ready || !iREN)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // RAM port drive according to the granted requester
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = 32'd0;
      ramstore = 32'd0;
      case (state_q)
         DSERVE: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
         end
         ISERVE: begin
            ramaddr  = iaddr;
            ramREN   = 1'b1;
         end
         default: begin
            ramREN   = 1'b0;
         end
      endcase
   end

   // Wait flags drop only in the completing cycle
   always_comb begin
      iwait = iREN & ~((state_q == ISERVE) & ram_ready);
      dwait = dreq & ~((state_q == DSERVE) & ram_ready);
   end

   assign iload = ramload;
   assign dload = ramload;

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Arbitrates the single-ported unified RAM between the instruction-fetch port and the data-memory port of the pipelined processor. The hazard unit stalls or flushes the pipeline based on the `iwait`/`dwait` outputs produced here. Data accesses have priority. A starvation counter forces an instruction grant after a bounded run of data grants, so fetch cannot be locked out indefinitely.

## Interface
- `STARVE_LIMIT`, default 4: maximum consecutive data grants while a fetch is pending. Legal range 1–15.
- `CLK` in 1: clock. All state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `iREN` in 1: instruction read request.
- `iaddr` in 32: instruction address.
- `iwait` out 1: instruction access not complete.
- `iload` out 32: fetched instruction word.
- `dREN` in 1: data read request.
- `dWEN` in 1: data write request.
- `daddr` in 32: data address.
- `dstore` in 32: write data.
- `dwait` out 1: data access not complete.
- `dload` out 32: read data.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ram_ready` in 1: RAM completes the current access this cycle.

## Operation
- Definitions: `dreq = dREN | dWEN`.
- FSM states: IDLE, DSERVE, ISERVE. Reset state is IDLE. Starvation counter `scnt` is 4 bits; reset value 0.
- IDLE transitions:
  - If `dreq` and not (`iREN` and `scnt == STARVE_LIMIT`), go to DSERVE.
  - Else, if `iREN`, go to ISERVE.
  - Else, stay in IDLE.
- `scnt` update in IDLE:
  - Moving to DSERVE with `iREN` high: `scnt` increments, saturating at STARVE_LIMIT.
  - Moving to ISERVE, or `iREN` low: `scnt` clears to 0.
- DSERVE drive:
  - `ramaddr = daddr`, `ramstore = dstore`, `ramWEN = dWEN`, `ramREN = dREN & ~dWEN`. Write wins if both requests are set.
- DSERVE exit:
  - If `ram_ready`, the access completes: `dwait = 0` that cycle, then IDLE.
  - If `dreq` drops before `ram_ready`, the access aborts: IDLE next cycle, no completion.
- ISERVE drive: `ramaddr = iaddr`, `ramREN = 1`, `ramWEN = 0`, `ramstore = 0`.
- ISERVE exit:
  - If `ram_ready`, the access completes: `iwait = 0` that cycle, then IDLE.
  - If `iREN` drops, the access aborts: IDLE next cycle.
- IDLE drive: `ramREN = ramWEN = 0`, `ramaddr = ramstore = 0`. `ram_ready` is ignored in IDLE.
- Wait outputs:
  - `iwait = iREN & ~(ISERVE & ram_ready)`.
  - `dwait = dreq & ~(DSERVE & ram_ready)`.
- `iload = dload = ramload`, passed combinationally. Valid only in the cycle the matching wait is low.
- Requesters hold address, data and enables stable until their wait drops. This module does not check that.

## Timing
- Reset values, with all inputs low: `iwait = dwait = 0`, all RAM outputs 0, FSM in IDLE, `scnt = 0`.
- With a request held during reset, its wait reads 1 and the RAM outputs stay 0.
- Latency:
  - A request seen in IDLE at cycle N enters a serve state at N+1.
  - If `ram_ready` is high at N+1, the wait drops at N+1. Minimum latency is 2 cycles.
  - Each cycle without `ram_ready` adds one cycle.
- Back-to-back: one mandatory IDLE cycle between consecutive transactions.
- Simultaneous `iREN` and `dreq` in IDLE: data wins unless `scnt == STARVE_LIMIT`.
- `RST` asserted in any state: IDLE and `scnt = 0` at the next edge. RAM enables are 0 from that edge. No completion is signalled for the aborted transaction.
- No combinational path from `ram_ready` to the FSM next-state other than the exit conditions above.

## Test plan
- Reset: hold `RST=1` for 2 cycles with `iREN=1`, `iaddr=0x40`. Required: `ramREN=0`, `iwait=1` throughout. Release reset. Next cycle: ISERVE, `ramREN=1`, `ramaddr=0x40`.
- Fetch with wait states: `iREN=1`, `iaddr=0x40`; `ram_ready` asserted on the 3rd ISERVE cycle with `ramload=0x8C220004`. Required: `iwait` low in exactly that cycle, `iload=0x8C220004`, `ramREN` high for 3 cycles then 0.
- Conflict: `iREN` and `dREN` rise together, `daddr=0x100`, `ram_ready=1`. Required sequence: DSERVE (`ramaddr=0x100`, `dwait=0`, `iwait=1`), IDLE, ISERVE (`ramaddr=iaddr`).
- Starvation, `STARVE_LIMIT=4`: `iREN` and `dWEN` held high continuously, `ram_ready=1`. Required: 4 data grants, then 1 instruction grant, then data resumes. This pattern repeats with `scnt` returning to 0 after each instruction grant.
- Write priority: `dREN=dWEN=1`, `daddr=0x200`, `dstore=0xDEADBEEF`. Required: `ramWEN=1`, `ramREN=0`, `ramstore=0xDEADBEEF`, `ramaddr=0x200`.
- Mid-transaction reset: assert `RST` for 1 cycle in DSERVE with `ram_ready=0`. Required: next cycle IDLE, RAM enables 0, `dwait` never low for that transaction, `scnt=0`.
